hamming74_serial_tx: RTL and testbench
======================================

Name: hamming74_serial_tx

Overview:
- Hamming(7,4) encoder and serializer: the transmit end of the team's 7-bit single-error-correcting link.
- Accepts 4-bit data nibbles over a valid/ready handshake and builds the 7-bit codeword in the bit layout the link decoder expects.
- Presents the codeword in parallel and shifts it out one bit per accepted beat, with backpressure, for the downstream serial channel.

Parameters:
- MSB_FIRST, 1, 1 = serialize codeword bit 6 first down to bit 0; 0 = bit 0 first up to bit 6.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- din  input  4  data nibble {d3,d2,d1,d0}
- din_valid  input  1  din is valid
- din_ready  output  1  block can accept din this cycle
- cw_out  output  7  registered codeword of the nibble currently being serialized
- ser_bit  output  1  current serial bit
- ser_valid  output  1  ser_bit is valid
- ser_ready  input  1  downstream consumes ser_bit this cycle
- ser_first  output  1  high while ser_bit is the first bit of a codeword
- ser_last  output  1  high while ser_bit is the last bit of a codeword

Behaviour:
- Codeword layout, cw[6:0]:
  - cw[4]=d3, cw[2]=d2, cw[1]=d1, cw[0]=d0
  - cw[6]=d3^d2^d0, cw[5]=d3^d1^d0, cw[3]=d2^d1^d0
- States: IDLE, SHIFT. A 3-bit bit counter idx runs 0..6 within SHIFT.
- Reset (rst=1 at a clock edge, from any state, including mid-codeword):
  - State goes to IDLE, idx=0.
  - cw_out=0, ser_bit=0, ser_valid=0, ser_first=0, ser_last=0.
  - The partially sent codeword is discarded.
  - din_ready=0 during the reset cycle; din_ready=1 from the first cycle after reset deasserts.
- IDLE:
  - ser_valid=0 and din_ready=1.
  - On din_valid&din_ready, the encoded codeword loads into cw_out, idx=0, and the state goes to SHIFT on the next cycle.
- SHIFT:
  - ser_valid=1.
  - ser_bit = cw_out[6-idx] when MSB_FIRST=1, else cw_out[idx].
  - ser_first=(idx==0), ser_last=(idx==6).
  - A bit is consumed when ser_valid&ser_ready. On consumption with idx<6, idx increments.
  - With ser_ready=0, ser_bit, idx and cw_out hold unchanged for any number of cycles.
  - din_ready = ser_ready & (idx==6), which is combinational from ser_ready.
  - On consumption of the last bit:
    - If din_valid is high, the new nibble loads, idx=0, and the block stays in SHIFT. There is no bubble: the next codeword's first bit is valid the following cycle.
    - Otherwise the state returns to IDLE and ser_valid drops the next cycle.
- Latency and throughput:
  - Nibble accepted at cycle N gives first serial bit valid at N+1.
  - Sustained throughput is 1 nibble per 7 cycles with ser_ready held high.
- din is sampled only on an accepting edge. din changes while din_ready=0 have no effect.
- cw_out is stable for the whole serialization and changes only on acceptance or reset.

Optional Feature:
- Macro: HAMMING_ERR_INJECT_EN.
- When defined:
  - Extra inputs err_en (1 bit) and err_pos (3 bits).
  - If err_en=1 at acceptance, the loaded codeword has bit cw[err_pos] inverted. Both cw_out and the serial stream carry the corrupted word.
  - err_pos=7 means no bit is flipped.
  - err_en/err_pos are sampled only at acceptance.
- When undefined:
  - The ports do not exist and the codeword is always the clean encoding.

Test Plan:
- Reset, then din=4'b1011 accepted, ser_ready=1 held, MSB_FIRST=1 -> cw_out=7'h33; serial stream 0,1,1,0,0,1,1 on 7 consecutive cycles; ser_first on the first bit, ser_last on the seventh; ser_valid low the cycle after.
- All 16 nibbles back-to-back with din_valid and ser_ready held high -> each codeword (0->7'h00, 4'h1->7'h69, 4'hF->7'h7F) matches the layout equations; no idle cycle between codewords; 112 bits in 112 cycles.
- din=4'hF, ser_ready toggled 1,0,0,1,... -> each bit held through stall cycles; din_ready stays 0 until the last bit is consumed; the stream is still seven 1s.
- MSB_FIRST=0, din=4'b0001 -> cw_out=7'h69; serial stream 1,0,0,1,0,1,1.
- Assert rst after 3 bits of din=4'hA are consumed -> next cycle ser_valid=0, cw_out=0, state IDLE; a following din=4'h5 serializes from its first bit correctly.
- With HAMMING_ERR_INJECT_EN: din=4'b1011, err_en=1, err_pos=4 -> cw_out=7'h23; the link decoder applied to cw_out returns 4'b1011. With err_pos=7 -> cw_out=7'h33.

Source files
------------

// File: rtl/hamming74_serial_tx.sv
// ---------------------------------------------------------------------------
// hamming74_serial_tx
//   Hamming(7,4) encoder and serializer for the 7-bit single-error-correcting
//   link. A nibble accepted on din/din_valid/din_ready is encoded into
//   cw[6:0] = {p6, p5, d3, p3, d2, d1, d0}
//     p6 = d3^d2^d0, p5 = d3^d1^d0, p3 = d2^d1^d0
//   and shifted out one bit per ser_valid&ser_ready beat.
//
// Parameters
//   MSB_FIRST : 1 = send cw[6] first down to cw[0]; 0 = cw[0] first.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active high
//   din        data nibble {d3,d2,d1,d0}
//   din_valid  din is valid
//   din_ready  block accepts din this cycle
//   cw_out     registered codeword being serialized
//   ser_bit    current serial bit
//   ser_valid  ser_bit is valid
//   ser_ready  downstream consumes ser_bit this cycle
//   ser_first  ser_bit is the first bit of a codeword
//   ser_last   ser_bit is the last bit of a codeword
//
// Optional feature (macro HAMMING_ERR_INJECT_EN)
//   err_en     flip one bit of the codeword loaded at acceptance
//   err_pos    index of the bit to flip; 7 flips nothing
// ---------------------------------------------------------------------------
module hamming74_serial_tx #(
   parameter int MSB_FIRST = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic [6:0] cw_out,
   output logic       ser_bit,
   output logic       ser_valid,
   input  logic       ser_ready,
   output logic       ser_first,
`ifdef HAMMING_ERR_INJECT_EN
   input  logic       err_en,
   input  logic [2:0] err_pos,
`endif
   output logic       ser_last
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t     state, state_nxt;
   logic [2:0] idx;
   logic       accept, consume, at_last;
   logic [6:0] cw_enc, flip;

   function automatic logic [6:0] encode(input logic [3:0] d);
      return {d[3] ^ d[2] ^ d[0],
              d[3] ^ d[1] ^ d[0],
              d[3],
              d[2] ^ d[1] ^ d[0],
              d[2],
              d[1],
              d[0]};
   endfunction

`ifdef HAMMING_ERR_INJECT_EN
   // One-hot of err_pos; bit 7 (err_pos=7) falls off the 7-bit word so
   // that position means "no flip".
   logic [7:0] flip_oh;
   assign flip_oh = 8'd1 << err_pos;
   assign flip    = err_en ? flip_oh[6:0] : 7'd0;
`else
   assign flip    = 7'd0;
`endif

   assign cw_enc  = encode(din) ^ flip;
   assign at_last = (idx == 3'd6);
   assign accept  = din_valid & din_ready;
   assign consume = ser_valid & ser_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SHIFT;
         SHIFT:   if (consume && at_last && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Codeword and bit counter
   always_ff @(posedge clk) begin
      if (rst) begin
         cw_out <= 7'd0;
         idx    <= 3'd0;
      end else if (accept) begin
         cw_out <= cw_enc;
         idx    <= 3'd0;
      end else if (consume) begin
         // Wrap to 0 when the final bit leaves so IDLE always starts clean.
         idx <= at_last ? 3'd0 : idx + 3'd1;
      end
   end

   // Outputs
   always_comb begin
      ser_valid = 1'b0;
      ser_bit   = 1'b0;
      ser_first = 1'b0;
      ser_last  = 1'b0;
      din_ready = 1'b0;
      if (state == SHIFT) begin
         ser_valid = 1'b1;
         ser_first = (idx == 3'd0);
         ser_last  = at_last;
         if (MSB_FIRST != 0) ser_bit = cw_out[3'd6 - idx];
         else                ser_bit = cw_out[idx];
         // Back-to-back reload only while the last bit is being taken.
         din_ready = ser_ready & at_last;
      end else begin
         din_ready = 1'b1;
      end
      // Nothing is accepted in the reset cycle itself.
      if (rst) din_ready = 1'b0;
   end

endmodule

// File: tb/tb_hamming74_serial_tx.sv
module tb_hamming74_serial_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] din;
   logic       din_valid;
   logic       ser_ready;
   logic       din_ready, ser_bit, ser_valid, ser_first, ser_last;
   logic [6:0] cw_out;
   logic       l_din_ready, l_ser_bit, l_ser_valid, l_ser_first, l_ser_last;
   logic [6:0] l_cw_out;
`ifdef HAMMING_ERR_INJECT_EN
   logic       err_en;
   logic [2:0] err_pos;
`endif

   int checks = 0;
   int errs   = 0;

   // Hand-computed codewords for nibbles 0..F
   logic [6:0] cw_tab [16] = '{7'h00, 7'h69, 7'h2A, 7'h43, 7'h4C, 7'h25, 7'h66, 7'h0F,
                               7'h70, 7'h19, 7'h5A, 7'h33, 7'h3C, 7'h55, 7'h16, 7'h7F};

   always #5 clk = ~clk;

   hamming74_serial_tx #(.MSB_FIRST(1)) dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .cw_out(cw_out), .ser_bit(ser_bit), .ser_valid(ser_valid), .ser_ready(ser_ready),
      .ser_first(ser_first),
`ifdef HAMMING_ERR_INJECT_EN
      .err_en(err_en), .err_pos(err_pos),
`endif
      .ser_last(ser_last));

   hamming74_serial_tx #(.MSB_FIRST(0)) dut_lsb (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(l_din_ready),
      .cw_out(l_cw_out), .ser_bit(l_ser_bit), .ser_valid(l_ser_valid), .ser_ready(ser_ready),
      .ser_first(l_ser_first),
`ifdef HAMMING_ERR_INJECT_EN
      .err_en(err_en), .err_pos(err_pos),
`endif
      .ser_last(l_ser_last));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one nibble from IDLE; returns at posedge+1 with the first bit up.
   task automatic send(input logic [3:0] n);
      din       = n;
      din_valid = 1'b1;
      @(posedge clk); #1;
      din_valid = 1'b0;
   endtask

   // Check seven consecutive bits with ser_ready high, then ser_valid low.
   task automatic expect_stream(input string tag, input logic [6:0] cw);
      for (int i = 0; i < 7; i++) begin
         @(negedge clk);
         chk({tag, "_valid"}, ser_valid, 1'b1);
         chk({tag, "_cw"},    cw_out, cw);
         chk({tag, "_msb"},   ser_bit, cw[6 - i]);
         chk({tag, "_lsb"},   l_ser_bit, cw[i]);
         chk({tag, "_first"}, ser_first, i == 0);
         chk({tag, "_last"},  ser_last, i == 6);
         chk({tag, "_rdy"},   din_ready, i == 6);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk({tag, "_idle"}, ser_valid, 1'b0);
      chk({tag, "_hold"}, cw_out, cw);
   endtask

`ifdef HAMMING_ERR_INJECT_EN
   function automatic logic [3:0] link_decode(input logic [6:0] c);
      logic [2:0] pos;
      logic [6:0] f;
      f = c;
      pos = {c[3] ^ c[2] ^ c[1] ^ c[0],
             c[5] ^ c[4] ^ c[1] ^ c[0],
             c[6] ^ c[4] ^ c[2] ^ c[0]};
      if (pos != 3'd0) f[3'd7 - pos] = ~f[3'd7 - pos];
      return {f[4], f[2], f[1], f[0]};
   endfunction
`endif

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      rst = 1'b1; din = 4'h0; din_valid = 1'b0; ser_ready = 1'b1;
`ifdef HAMMING_ERR_INJECT_EN
      err_en = 1'b0; err_pos = 3'd7;
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_din_ready", din_ready, 1'b0);
      chk("rst_valid", ser_valid, 1'b0);
      chk("rst_cw", cw_out, 7'h00);
      chk("rst_bit", ser_bit, 1'b0);
      chk("rst_first", ser_first, 1'b0);
      chk("rst_last", ser_last, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("post_rst_ready", din_ready, 1'b1);

      // Single nibble, MSB first: 0110011
      send(4'hB);
      expect_stream("b", 7'h33);

      // All 16 nibbles back to back, no bubbles
      din = 4'h0; din_valid = 1'b1; ser_ready = 1'b1;
      @(posedge clk); #1 din = 4'h1;
      for (int k = 0; k < 112; k++) begin
         @(negedge clk);
         chk("b2b_valid", ser_valid, 1'b1);
         chk("b2b_bit", ser_bit, cw_tab[k / 7][6 - (k % 7)]);
         if (k % 7 == 0) begin
            chk("b2b_cw", cw_out, cw_tab[k / 7]);
            chk("b2b_first", ser_first, 1'b1);
         end
         if (k % 7 == 6) chk("b2b_rdy", din_ready, 1'b1);
         @(posedge clk); #1;
         if (k % 7 == 6) begin
            if (k / 7 + 2 <= 15) din = 4'(k / 7 + 2);
            if (k / 7 == 14) din_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("b2b_end", ser_valid, 1'b0);

      // Backpressure: ser_ready 1,0,0,1,... ; din wiggles with din_valid low
      send(4'hF);
      cnt = 0;
      for (int c = 0; c < 40 && cnt < 7; c++) begin
         ser_ready = (c % 3 == 0);
         din = 4'(c);
         @(negedge clk);
         chk("stall_valid", ser_valid, 1'b1);
         chk("stall_bit", ser_bit, 1'b1);
         chk("stall_cw", cw_out, 7'h7F);
         chk("stall_first", ser_first, cnt == 0);
         chk("stall_last", ser_last, cnt == 6);
         chk("stall_rdy", din_ready, ser_ready && cnt == 6);
         if (ser_ready) cnt++;
         @(posedge clk); #1;
      end
      chk("stall_count", cnt, 7);
      ser_ready = 1'b1;
      @(negedge clk);
      chk("stall_end", ser_valid, 1'b0);

      // LSB-first instance: nibble 1 -> 7'h69, stream 1,0,0,1,0,1,1
      send(4'h1);
      chk("lsb_cw", l_cw_out, 7'h69);
      expect_stream("one", 7'h69);

      // Reset in the middle of nibble A (1011010)
      send(4'hA);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mid_bit", ser_bit, cw_tab[10][6 - i]);
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", din_ready, 1'b0);
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_valid", ser_valid, 1'b0);
      chk("mid_rst_cw", cw_out, 7'h00);
      chk("mid_rst_first", ser_first, 1'b0);
      chk("mid_rst_ready2", din_ready, 1'b1);
      send(4'h5);
      expect_stream("five", 7'h25);

`ifdef HAMMING_ERR_INJECT_EN
      err_en = 1'b1; err_pos = 3'd4;
      send(4'hB);
      err_en = 1'b0;
      chk("inj_cw", cw_out, 7'h23);
      chk("inj_decode", link_decode(cw_out), 4'hB);
      expect_stream("inj", 7'h23);
      err_en = 1'b1; err_pos = 3'd7;
      send(4'hB);
      err_en = 1'b0;
      expect_stream("inj7", 7'h33);
`endif

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
